// File: rtl/conv_encoder_framed_if.sv
// -----------------------------------------------------------------------------
// conv_encoder_framed_if
//   Bit-in / symbol-out link between an upstream bit source and the framed
//   convolutional encoder.
//
//   Handshake: a data bit moves on a rising clock edge where enable_i and
//   ready_o are both high. ready_o is a combinational output of the encoder.
//   enable_i may be raised at any time. Bits offered while ready_o is low are
//   ignored, so the source must honour ready_o. valid_o marks a d_out symbol
//   for exactly one cycle, and the consumer has no back-pressure.
//
//   Signals
//     enable_i      source -> encoder  a data bit is offered this cycle
//     d_in          source -> encoder  data bit
//     ready_o       encoder -> source  encoder can accept a bit this cycle
//     valid_o       encoder -> sink    d_out carries a new symbol
//     d_out[1:0]    encoder -> sink    code symbol {G0 parity, G1 parity}
//     frame_done_o  encoder -> sink    pulse with the last tail symbol
// -----------------------------------------------------------------------------
interface conv_encoder_framed_if;
    logic       enable_i;
    logic       d_in;
    logic       ready_o;
    logic       valid_o;
    logic [1:0] d_out;
    logic       frame_done_o;

    modport master (
        output enable_i,
        output d_in,
        input  ready_o,
        input  valid_o,
        input  d_out,
        input  frame_done_o
    );

    modport slave (
        input  enable_i,
        input  d_in,
        output ready_o,
        output valid_o,
        output d_out,
        output frame_done_o
    );
endinterface

// File: rtl/conv_encoder_framed.sv
// -----------------------------------------------------------------------------
// conv_encoder_framed
//   Rate-1/2 feedforward convolutional encoder with frame termination.
//   The encoder produces one 2-bit symbol for each accepted data bit. After
//   every FRAME_LEN data bits it flushes K-1 zero tail bits, so the decoder
//   trellis ends in state 0.
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous, active-low reset
//     bus        conv_encoder_framed_if.slave (handshake, symbol, frame pulse)
//     dbg_state  current FSM state (0 IDLE, 1 DATA, 2 TAIL)
//
//   Parameters
//     K          constraint length (3..9). The state register is K-1 bits wide.
//     G0, G1     generator polynomials for d_out[1] and d_out[0]. Bit K-1 taps
//                the input bit and bit 0 taps the oldest state bit.
//     FRAME_LEN  number of data bits per frame (>= 1)
//     ERR_N      error-injection period exponent
//
//   Optional feature (macro ERR_INJ_EN)
//     When ERR_INJ_EN is defined, a symbol counter inverts d_out[0] on every
//     2**ERR_N-th symbol. This gives deterministic channel errors for decoder
//     stress tests. When ERR_INJ_EN is undefined, d_out is always the clean
//     code symbol.
// -----------------------------------------------------------------------------
module conv_encoder_framed #(
    parameter int             K         = 3,
    parameter logic [K-1:0]   G0        = 3'b111,
    parameter logic [K-1:0]   G1        = 3'b101,
    parameter int             FRAME_LEN = 16,
    parameter int             ERR_N     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    conv_encoder_framed_if.slave  bus,
    output logic [1:0]            dbg_state
);

    localparam int BW = $clog2(FRAME_LEN + 1);
    localparam int TW = $clog2(K);
    localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_LEN);
    localparam logic [TW-1:0] LAST_TAIL = TW'(K - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [K-2:0]    enc_st;       // enc_st[K-2] holds the most recent past bit
    logic [BW-1:0]   bit_ct, bit_ct_nx;
    logic [TW-1:0]   tail_ct, tail_ct_nx;
    logic            accept;
    logic            shift;        // a symbol is produced on this edge
    logic            done_nx;
    logic            x;            // encoder input bit for this cycle
    logic [K-1:0]    u;
    logic [1:0]      sym;
    logic            err_flip;

    assign dbg_state   = state;
    assign bus.ready_o = (state != S_TAIL);
    assign accept      = bus.enable_i && bus.ready_o;

    // Tail cycles feed zeros. In other states the offered bit is only used
    // when it is actually accepted.
    assign x   = (state == S_TAIL) ? 1'b0 : bus.d_in;
    assign u   = {x, enc_st};
    assign sym = {^(u & G0), ^(u & G1)};

    always_comb begin
        state_nx   = state;
        bit_ct_nx  = bit_ct;
        tail_ct_nx = tail_ct;
        shift      = 1'b0;
        done_nx    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    shift     = 1'b1;
                    bit_ct_nx = BW'(1);
                    state_nx  = (FRAME_LEN == 1) ? S_TAIL : S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    shift     = 1'b1;
                    bit_ct_nx = bit_ct + BW'(1);
                    if (bit_ct + BW'(1) == LAST_BIT) begin
                        state_nx = S_TAIL;
                    end
                end
            end
            S_TAIL: begin
                shift = 1'b1;
                if (tail_ct == LAST_TAIL) begin
                    done_nx    = 1'b1;
                    bit_ct_nx  = '0;
                    tail_ct_nx = '0;
                    state_nx   = S_IDLE;
                end else begin
                    tail_ct_nx = tail_ct + TW'(1);
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

`ifdef ERR_INJ_EN
    // This counter is free running and is cleared only by reset. It is
    // sampled before it increments, so symbols 2**ERR_N, 2*2**ERR_N and so on
    // are the ones that get corrupted.
    logic [ERR_N-1:0] sym_ct;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sym_ct <= '0;
        end else if (shift) begin
            sym_ct <= sym_ct + ERR_N'(1);
        end
    end

    assign err_flip = shift && (&sym_ct);
`else
    logic unused_err_n;
    assign err_flip     = 1'b0;
    assign unused_err_n = ERR_N[0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= S_IDLE;
            enc_st           <= '0;
            bit_ct           <= '0;
            tail_ct          <= '0;
            bus.valid_o      <= 1'b0;
            bus.d_out        <= 2'b00;
            bus.frame_done_o <= 1'b0;
        end else begin
            state            <= state_nx;
            bit_ct           <= bit_ct_nx;
            tail_ct          <= tail_ct_nx;
            bus.valid_o      <= shift;
            bus.frame_done_o <= done_nx;
            if (shift) begin
                enc_st    <= {x, enc_st[K-2:1]};
                bus.d_out <= {sym[1], sym[0] ^ err_flip};
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder_framed.sv
// -----------------------------------------------------------------------------
// tb_conv_encoder_framed
//   Directed, table-driven bench for conv_encoder_framed with K=3, G0=111,
//   G1=101, FRAME_LEN=4 and ERR_N=2.
//
//   Each table row describes one clock cycle. It gives the inputs driven in
//   that cycle, the ready_o value expected during the cycle, and the
//   registered outputs expected after the closing rising edge. When
//   ERR_INJ_EN is defined, the expected d_out[0] is inverted on every 4th
//   symbol since the last reset.
// -----------------------------------------------------------------------------
module tb_conv_encoder_framed;

    localparam int ERR_N = 2;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    conv_encoder_framed_if bus ();

    conv_encoder_framed #(
        .K         (3),
        .G0        (3'b111),
        .G1        (3'b101),
        .FRAME_LEN (4),
        .ERR_N     (ERR_N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic       en;
        logic       d;
        logic       rdy;
        logic       v;
        logic [1:0] dout;
        logic       done;
    } vec_t;

    vec_t       vecs[$];
    int         checks;
    int         errors;
    int         sym_seen;
    logic [1:0] last_dout;

    task automatic add(input logic en, input logic d, input logic rdy,
                       input logic v, input logic [1:0] dout, input logic done);
        vec_t r;
        r.en   = en;
        r.d    = d;
        r.rdy  = rdy;
        r.v    = v;
        r.dout = dout;
        r.done = done;
        vecs.push_back(r);
    endtask

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_row(input vec_t r, input int idx);
        logic [1:0] e;
        @(negedge clk);
        check1($sformatf("ready_o[%0d]", idx), {31'd0, bus.ready_o}, {31'd0, r.rdy});
        bus.enable_i = r.en;
        bus.d_in     = r.d;
        @(posedge clk);
        #1;
        check1($sformatf("valid_o[%0d]", idx), {31'd0, bus.valid_o}, {31'd0, r.v});
        check1($sformatf("frame_done_o[%0d]", idx), {31'd0, bus.frame_done_o}, {31'd0, r.done});
        if (r.v) begin
            e = r.dout;
`ifdef ERR_INJ_EN
            if (sym_seen[ERR_N-1:0] == 2'b11) e[0] = ~e[0];
`endif
            sym_seen++;
            last_dout = e;
        end else begin
            e = last_dout;
        end
        check1($sformatf("d_out[%0d]", idx), {30'd0, bus.d_out}, {30'd0, e});
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) run_row(vecs[i], i);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.enable_i = 1'b0;
        bus.d_in     = 1'b0;
        rst          = 1'b0;
        sym_seen     = 0;
        last_dout    = 2'b00;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, " d_out"}, {30'd0, bus.d_out}, 32'd0);
        check1({tag, " valid_o"}, {31'd0, bus.valid_o}, 32'd0);
        check1({tag, " ready_o"}, {31'd0, bus.ready_o}, 32'd1);
        check1({tag, " frame_done_o"}, {31'd0, bus.frame_done_o}, 32'd0);
        check1({tag, " state"}, {30'd0, dbg_state}, 32'd0);
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t r;
        checks       = 0;
        errors       = 0;
        sym_seen     = 0;
        last_dout    = 2'b00;
        rst          = 1'b0;
        bus.enable_i = 1'b0;
        bus.d_in     = 1'b0;

        // Section A (rows 0..6): frame 1,0,1,1 with enable held high.
        add(1, 1, 1, 1, 2'b11, 0);
        add(1, 0, 1, 1, 2'b10, 0);
        add(1, 1, 1, 1, 2'b00, 0);
        add(1, 1, 1, 1, 2'b01, 0);
        add(0, 0, 0, 1, 2'b01, 0);
        add(0, 0, 0, 1, 2'b11, 1);
        add(0, 0, 1, 0, 2'b11, 0);
        // Section B (rows 7..14): same frame with a one-cycle gap after bit 2.
        add(1, 1, 1, 1, 2'b11, 0);
        add(1, 0, 1, 1, 2'b10, 0);
        add(0, 1, 1, 0, 2'b10, 0);
        add(1, 1, 1, 1, 2'b00, 0);
        add(1, 1, 1, 1, 2'b01, 0);
        add(0, 0, 0, 1, 2'b01, 0);
        add(0, 0, 0, 1, 2'b11, 1);
        add(0, 0, 1, 0, 2'b11, 0);
        // Section C (rows 15..27): two frames back to back, enable always high.
        add(1, 1, 1, 1, 2'b11, 0);
        add(1, 0, 1, 1, 2'b10, 0);
        add(1, 1, 1, 1, 2'b00, 0);
        add(1, 1, 1, 1, 2'b01, 0);
        add(1, 1, 0, 1, 2'b01, 0);
        add(1, 1, 0, 1, 2'b11, 1);
        add(1, 1, 1, 1, 2'b11, 0);
        add(1, 0, 1, 1, 2'b10, 0);
        add(1, 1, 1, 1, 2'b00, 0);
        add(1, 1, 1, 1, 2'b01, 0);
        add(1, 0, 0, 1, 2'b01, 0);
        add(1, 0, 0, 1, 2'b11, 1);
        add(0, 0, 1, 0, 2'b11, 0);
        // Section D (rows 28..40): two all-zero frames, 12 symbols.
        for (int f = 0; f < 2; f++) begin
            for (int b = 0; b < 4; b++) add(1, 0, 1, 1, 2'b00, 0);
            add(1, 0, 0, 1, 2'b00, 0);
            add(1, 0, 0, 1, 2'b00, 1);
        end
        add(0, 0, 1, 0, 2'b00, 0);

        // Reset state while rst is held low.
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        run_range(0, 6);
        run_range(7, 14);
        run_range(15, 27);

        // Reset in the middle of a frame, after two bits have been accepted.
        run_row(vecs[0], 100);
        run_row(vecs[1], 101);
        #2;
        rst       = 1'b0;
        sym_seen  = 0;
        last_dout = 2'b00;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        bus.enable_i = 1'b0;
        rst          = 1'b1;
        // The restarted frame must match a fresh frame.
        run_range(0, 6);

        // Zero frames start from a clean reset so the error positions line up.
        do_reset();
        run_range(28, 40);

        // Idle: further enables low keep valid_o low and d_out held.
        r.en = 1'b0; r.d = 1'b1; r.rdy = 1'b1; r.v = 1'b0; r.dout = 2'b00; r.done = 1'b0;
        run_row(r, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_encoder_framed.md
Name: conv_encoder_framed

Overview:
Rate-1/2 feedforward convolutional encoder with frame handling. It is the transmit-side counterpart of the Viterbi decoder and drives the channel path that feeds the decoder's 2-bit symbol input.
- Accepts one data bit per handshake.
- Emits one 2-bit code symbol per accepted bit.
- After every FRAME_LEN data bits, appends K-1 zero tail bits so the decoder trellis terminates in state 0.

Parameters:
K, 3, constraint length (3..9); encoder state register is K-1 bits
G0, 3'b111, generator polynomial for d_out[1], K bits; bit K-1 taps d_in, bit 0 taps oldest state bit
G1, 3'b101, generator polynomial for d_out[0], same tap ordering
FRAME_LEN, 16, data bits per frame (>=1); sets width of bit counter
ERR_N, 3, error-injection period exponent; used only with ERR_INJ_EN

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
enable_i  input  1  upstream offers d_in this cycle
d_in  input  1  data bit
ready_o  output  1  encoder can accept a bit this cycle
valid_o  output  1  d_out carries a valid symbol
d_out  output  2  code symbol {G0 parity, G1 parity}
frame_done_o  output  1  one-cycle pulse coincident with the last tail symbol

Behaviour:
- Reset (rst low, async):
  - FSM goes to IDLE; state register, bit counter and symbol counter clear to 0.
  - Outputs: d_out=2'b00, valid_o=0, frame_done_o=0, ready_o=1.
- Accept: a bit is accepted on a rising edge where enable_i && ready_o.
  - ready_o is combinational: 1 in IDLE and DATA, 0 in TAIL.
- Encoding: let u = {x, state[K-2:0]}, where x is the encoder input for this cycle (the accepted d_in in IDLE/DATA, 0 in TAIL) and state[K-2] is the most recent past bit.
  - d_out[1] = ^(u & G0); d_out[0] = ^(u & G1).
  - On the same edge, state shifts: state <= {x, state[K-2:1]}.
- Latency: d_out and valid_o are registered, so they appear 1 cycle after acceptance.
  - valid_o=1 for exactly one cycle per accepted or tail bit, 0 otherwise.
  - When valid_o=0, d_out holds its last value.
- FSM:
  - IDLE: on accept, encode the bit, bit_ct<=1, go to DATA. If FRAME_LEN==1, go straight to TAIL.
  - DATA: on accept, encode and increment bit_ct. The accept that reaches FRAME_LEN goes to TAIL. With no accept, state holds and the next cycle has valid_o=0 (gaps are allowed).
  - TAIL: for K-1 consecutive cycles, encode x=0 with valid_o=1. enable_i is ignored (upstream must honour ready_o). On the last tail cycle, set frame_done_o=1 with that symbol, clear bit_ct, and go to IDLE. The state register is all-zero after the flush.
- Back-to-back frames: IDLE can accept on the cycle after TAIL exits. The throughput gap is exactly K-1 cycles per frame.
- Reset mid-frame: all state is discarded immediately; no tail is sent; outputs return to reset values.
- Counter widths: bit_ct uses $clog2(FRAME_LEN+1) bits and never wraps. The tail counter uses $clog2(K) bits.

Optional Feature:
Macro ERR_INJ_EN.
- Defined: a free-running symbol counter sym_ct increments on every valid_o symbol. When sym_ct[ERR_N-1:0]=='1, d_out[0] is inverted on that symbol, giving one deterministic single-bit channel error every 2**ERR_N symbols for decoder stress tests. sym_ct clears on reset only.
- Undefined: no counter and no inversion; d_out is always the clean code symbol.

Test Plan:
- Reset with rst=0 mid-cycle -> d_out=00, valid_o=0, ready_o=1, frame_done_o=0 asynchronously.
- K=3, G0=111, G1=101, FRAME_LEN=4; input bits 1,0,1,1 with enable_i held high -> symbols 11,10,00,01, then tail 01,11; frame_done_o high with the 11 symbol; ready_o=0 for the 2 tail cycles.
- Same frame with enable_i low between the 2nd and 3rd bit -> one cycle of valid_o=0 in the gap; the symbol sequence is unchanged.
- Two frames back-to-back with enable_i held high -> enable_i is ignored during TAIL; the second frame's first symbol appears 3 cycles after the first frame's last data symbol; the second frame's symbols match the single-frame case.
- rst asserted after 2 bits of a frame, then the frame is restarted -> output equals a fresh frame (11,10,00,01,01,11); no stale state.
- ERR_INJ_EN defined, ERR_N=2, all-zero input over 2 frames (12 symbols) -> symbols 4, 8 and 12 are 01; all other symbols are 00.
